// File: rtl/reg_skid_slice.sv
// One registered valid/ready slice with a main register and a skid register.
// The upstream ready is taken straight from the skid flop, so no ready path is combinational.
module reg_skid_slice #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);

  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             main_v_q, main_v_d;
  logic             skid_v_q, skid_v_d;
  logic             s_xfer;

  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    s_xfer   = s_valid && !skid_v_q;

    if (clear) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q || m_ready) begin
      // Main is free this edge: drain skid first so ordering is kept.
      skid_v_d = 1'b0;
      if (skid_v_q) begin
        main_d   = skid_q;
        main_v_d = 1'b1;
      end else if (s_xfer) begin
        main_d   = s_data;
        main_v_d = 1'b1;
      end else begin
        main_v_d = 1'b0;
      end
    end else if (s_xfer) begin
      skid_d   = s_data;
      skid_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
    end
  end

  assign s_ready = !skid_v_q;
  assign m_valid = main_v_q;
  assign m_data  = main_q;

endmodule

// File: rtl/reg_pipe_skid.sv
// Chain of STAGES skid slices carrying WIDTH-bit words with valid/ready,
// plus a flush input and a count of words currently held.
module reg_pipe_skid #(
  parameter int  WIDTH  = 5,
  parameter int  STAGES = 2,
  localparam int CNT_W  = $clog2(2*STAGES+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] occupancy
);

  logic [STAGES:0]  vld;
  logic [STAGES:0]  rdy;
  logic [WIDTH-1:0] dat [STAGES+1];

  assign vld[0]      = in_valid;
  assign dat[0]      = in_data;
  assign in_ready    = rdy[0];
  assign rdy[STAGES] = out_ready;
  assign out_valid   = vld[STAGES];
  assign out_data    = dat[STAGES];

  for (genvar g = 0; g < STAGES; g++) begin : g_slice
    reg_skid_slice #(.WIDTH(WIDTH)) u_slice (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (clear),
      .s_valid (vld[g]),
      .s_ready (rdy[g]),
      .s_data  (dat[g]),
      .m_valid (vld[g+1]),
      .m_ready (rdy[g+1]),
      .m_data  (dat[g+1])
    );
  end

  logic [CNT_W-1:0] occ_q, occ_d;
  logic             in_xfer, out_xfer;

  always_comb begin
    occ_d    = occ_q;
    in_xfer  = in_valid && in_ready;
    out_xfer = out_valid && out_ready;
    // Flush wins over any handshake on the same edge.
    if (clear) begin
      occ_d = '0;
    end else if (in_xfer && !out_xfer) begin
      occ_d = occ_q + CNT_W'(1);
    end else if (out_xfer && !in_xfer) begin
      occ_d = occ_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

endmodule

// File: tb/tb_reg_pipe_skid.sv
// Bench for reg_pipe_skid: directed phases plus random stalls, checked against a word-queue model.
module tb_reg_pipe_skid;
  localparam int WIDTH  = 5;
  localparam int STAGES = 2;
  localparam int CNT_W  = $clog2(2*STAGES+1);
  localparam int CAP    = 2*STAGES;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] occupancy;

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] popped[$];

  reg_pipe_skid #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: note handshakes before the edge, update the queue model, check after the edge.
  task automatic cyc();
    bit               in_x, out_x, hold, live;
    logic [WIDTH-1:0] hd;
    in_x  = in_valid && in_ready;
    out_x = out_valid && out_ready;
    hold  = out_valid && !out_ready;
    hd    = out_data;
    @(posedge clk);
    live = rst_n && !clear;
    if (!live) begin
      q.delete();
    end else begin
      if (out_x) begin
        popped.push_back(hd);
        if (q.size() > 0) void'(q.pop_front());
      end
      if (in_x) q.push_back(in_data);
    end
    #1;
    chk("occ_vs_model", 32'(occupancy), q.size());
    chk("occ_cap", 32'(occupancy <= CAP), 1);
    chk("full_blocks_in", 32'((q.size() == CAP) && in_ready), 0);
    chk("valid_while_empty", 32'(out_valid && (q.size() == 0)), 0);
    if (out_valid && q.size() > 0) chk("head_word", 32'(out_data), 32'(q[0]));
    if (hold && live) begin
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_data", 32'(out_data), 32'(hd));
    end
  endtask

  initial begin
    bit acc;
    bit seen;
    logic [WIDTH-1:0] exp_w;

    // Reset held for three cycles
    repeat (3) cyc();
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_occupancy", 32'(occupancy), 0);
    rst_n = 1'b1;

    // Streaming with no backpressure: two-cycle latency, one word per cycle
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      in_valid = (k < 5);
      in_data  = WIDTH'(k + 1);
      cyc();
      chk("stream_valid", 32'(out_valid), 32'((k >= 1) && (k <= 5)));
      if (k >= 1 && k <= 5) chk("stream_data", 32'(out_data), k);
      if (k >= 1 && k <= 4) chk("stream_occ", 32'(occupancy), 2);
    end
    chk("stream_empty", 32'(occupancy), 0);

    // Backpressure until full, then drain
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(5'h0A + i);
      cyc();
    end
    chk("full_occ", 32'(occupancy), 4);
    chk("full_in_ready", 32'(in_ready), 0);
    popped.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      acc = in_valid && in_ready;
      cyc();
      if (acc) in_valid = 1'b0;
    end
    chk("drain_count", popped.size(), 5);
    for (int i = 0; i < 5 && i < popped.size(); i++) begin
      exp_w = WIDTH'(5'h0A + i);
      chk("drain_order", 32'(popped[i]), 32'(exp_w));
    end
    chk("drain_occ", 32'(occupancy), 0);

    // Random valid/ready with an incrementing data pattern
    for (int i = 0; i < 200; i++) begin
      in_valid  = 1'($urandom % 2);
      out_ready = 1'($urandom % 2);
      in_data   = WIDTH'(i);
      cyc();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) cyc();
    chk("random_drained", 32'(occupancy), 0);

    // Flush with a word offered on the same edge
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(5'h11 + i);
      cyc();
    end
    chk("flush_prefill", 32'(occupancy), 3);
    clear    = 1'b1;
    in_data  = 5'h1F;
    cyc();
    chk("flush_occ", 32'(occupancy), 0);
    chk("flush_out_valid", 32'(out_valid), 0);
    chk("flush_in_ready", 32'(in_ready), 1);
    clear     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    popped.delete();
    repeat (6) cyc();
    seen = 1'b0;
    foreach (popped[i]) if (popped[i] == 5'h1F) seen = 1'b1;
    chk("flush_no_1f", 32'(seen), 0);
    chk("flush_no_output", popped.size(), 0);

    // Asynchronous reset while full
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(5'h15 + i);
      cyc();
    end
    chk("pre_reset_occ", 32'(occupancy), 4);
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_in_ready", 32'(in_ready), 1);
    chk("async_out_valid", 32'(out_valid), 0);
    chk("async_out_data", 32'(out_data), 0);
    chk("async_occ", 32'(occupancy), 0);
    cyc();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    popped.delete();
    for (int i = 0; i < 7; i++) begin
      in_valid = (i < 2);
      in_data  = WIDTH'(5'h07 + i);
      cyc();
    end
    chk("resume_count", popped.size(), 2);
    if (popped.size() == 2) begin
      chk("resume_w0", 32'(popped[0]), 32'h07);
      chk("resume_w1", 32'(popped[1]), 32'h08);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
